// File: rtl/insn_pkg.sv
// Shared field positions and the decoded-instruction record for the micro-BESM
// instruction decoder. Used by insn_decoder and, when BESM6_COMPAT_EN is defined, besm6_unpack.
package insn_pkg;

  // Native format: 32-bit half
  localparam int NAT_IR_MSB   = 31;
  localparam int NAT_IR_LSB   = 28;
  localparam int NAT_OP_MSB   = 27;
  localparam int NAT_OP_LSB   = 20;
  localparam int NAT_EXT_BIT  = 27;
  localparam int NAT_ADDR_MSB = 19;
  localparam int NAT_ADDR_LSB = 0;

  // BESM-6 format: 24-bit half
  localparam int B6_IR_MSB    = 23;
  localparam int B6_IR_LSB    = 20;
  localparam int B6_LONG_BIT  = 19;
  localparam int B6_LOP_MSB   = 18;
  localparam int B6_LOP_LSB   = 15;
  localparam int B6_LADDR_MSB = 14;
  localparam int B6_SOP_MSB   = 17;
  localparam int B6_SOP_LSB   = 12;
  localparam int B6_SEXT_BIT  = 18;
  localparam int B6_SADDR_MSB = 11;

  // Fills address bits 14:12 to reach the 070000-octal region
  localparam logic [2:0] ADDR_EXT = 3'b111;

  typedef struct packed {
    logic [3:0]  ir;
    logic [7:0]  op;
    logic        extop;
    logic [19:0] addr;
  } decoded_insn_t;

endpackage

// File: rtl/besm6_unpack.sv
// Combinational split of one 24-bit BESM-6 instruction half into its fields,
// covering both the long (extended opcode) and short sub-formats.
module besm6_unpack
  import insn_pkg::*;
(
  input  logic [23:0]   half,
  output decoded_insn_t dec
);

  always_comb begin
    dec    = '0;
    dec.ir = half[B6_IR_MSB:B6_IR_LSB];
    if (half[B6_LONG_BIT]) begin
      dec.extop = 1'b1;
      dec.op    = {4'b0001, half[B6_LOP_MSB:B6_LOP_LSB]};
      dec.addr  = {5'b0, half[B6_LADDR_MSB:0]};
    end else begin
      dec.extop = 1'b0;
      dec.op    = {2'b00, half[B6_SOP_MSB:B6_SOP_LSB]};
      // Short addresses are 12 bits; bit 18 relocates them into the 070000 region
      dec.addr  = {5'b0, (half[B6_SEXT_BIT] ? ADDR_EXT : 3'b000),
                   half[B6_SADDR_MSB:0]};
    end
  end

endmodule

// File: rtl/insn_decoder.sv
// micro-BESM instruction-field decoder: selects the left/right instruction of a
// 64-bit word and registers its fields. Macro BESM6_COMPAT_EN enables the pe=1 BESM-6 format.
module insn_decoder
  import insn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] word,
  input  logic        pe,
  input  logic        tkk,
  output logic [3:0]  ir,
  output logic [7:0]  op,
  output logic        extop,
  output logic [19:0] addr
);

  logic [31:0]   nat_half_p0;
  decoded_insn_t nat_p0;
  decoded_insn_t dec_p0;
  decoded_insn_t dec_p1;

  // ---- stage p0: combinational decode of the selected half ----
  always_comb begin
    nat_half_p0  = tkk ? word[31:0] : word[63:32];
    nat_p0.ir    = nat_half_p0[NAT_IR_MSB:NAT_IR_LSB];
    nat_p0.op    = nat_half_p0[NAT_OP_MSB:NAT_OP_LSB];
    nat_p0.extop = nat_half_p0[NAT_EXT_BIT];
    nat_p0.addr  = nat_half_p0[NAT_ADDR_MSB:NAT_ADDR_LSB];
  end

`ifdef BESM6_COMPAT_EN
  logic [23:0]   b6_half_p0;
  decoded_insn_t b6_p0;

  // Tag bits word[63:48] never reach the BESM-6 path
  assign b6_half_p0 = tkk ? word[23:0] : word[47:24];

  besm6_unpack u_besm6_unpack (
    .half (b6_half_p0),
    .dec  (b6_p0)
  );

  assign dec_p0 = pe ? b6_p0 : nat_p0;
`else
  logic unused_pe;

  assign unused_pe = pe;
  assign dec_p0    = nat_p0;
`endif

  // ---- stage p1: output register, cleared asynchronously ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_p1 <= '0;
    end else begin
      dec_p1 <= dec_p0;
    end
  end

  assign ir    = dec_p1.ir;
  assign op    = dec_p1.op;
  assign extop = dec_p1.extop;
  assign addr  = dec_p1.addr;

endmodule

// File: tb/tb_insn_decoder.sv
// Scoreboard bench for insn_decoder: directed vectors plus walking-bit sweeps,
// expectations follow BESM6_COMPAT_EN (pe ignored when it is undefined).
module tb_insn_decoder;
  import insn_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] word;
  logic        pe;
  logic        tkk;
  logic [3:0]  ir;
  logic [7:0]  op;
  logic        extop;
  logic [19:0] addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    decoded_insn_t d;
    string         nm;
  } sb_t;

  sb_t exp_q[$];

  insn_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .word  (word),
    .pe    (pe),
    .tkk   (tkk),
    .ir    (ir),
    .op    (op),
    .extop (extop),
    .addr  (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decoded_insn_t mk(input logic [3:0] i, input logic [7:0] o,
                                       input logic e, input logic [19:0] a);
    decoded_insn_t r;
    r.ir = i; r.op = o; r.extop = e; r.addr = a;
    return r;
  endfunction

  // Independent reference written with shifts and masks
  function automatic decoded_insn_t ref_model(input logic [63:0] w, input logic p,
                                              input logic t);
    decoded_insn_t r;
    logic [63:0]   h;
    logic          use_b6;
`ifdef BESM6_COMPAT_EN
    use_b6 = p;
`else
    use_b6 = p & 1'b0;
`endif
    if (use_b6) begin
      h    = t ? (w & 64'hFF_FFFF) : ((w >> 24) & 64'hFF_FFFF);
      r.ir = 4'((h >> 20) & 64'hF);
      if (h[19]) begin
        r.extop = 1'b1;
        r.op    = 8'(64'h10 | ((h >> 15) & 64'hF));
        r.addr  = 20'(h & 64'h7FFF);
      end else begin
        r.extop = 1'b0;
        r.op    = 8'((h >> 12) & 64'h3F);
        r.addr  = 20'((h & 64'hFFF) | (h[18] ? 64'h7000 : 64'h0));
      end
    end else begin
      h       = t ? (w & 64'hFFFF_FFFF) : (w >> 32);
      r.ir    = 4'(h >> 28);
      r.op    = 8'(h >> 20);
      r.extop = h[27];
      r.addr  = 20'(h);
    end
    return r;
  endfunction

  task automatic step(input logic [63:0] w, input logic p, input logic t,
                      input decoded_insn_t e, input string nm);
    sb_t s;
    @(posedge clk);
    #1;
    word = w; pe = p; tkk = t;
    s.d = e; s.nm = nm;
    exp_q.push_back(s);
  endtask

  task automatic chk_now(input string nm, input decoded_insn_t want);
    decoded_insn_t got;
    got = mk(ir, op, extop, addr);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got ir=%h op=%h extop=%b addr=%h want ir=%h op=%h extop=%b addr=%h",
               nm, got.ir, got.op, got.extop, got.addr,
               want.ir, want.op, want.extop, want.addr);
    end
  endtask

  // Monitor: every edge out of reset with a pending entry produces one result
  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      if (rst_n && exp_q.size() > 0) begin
        s = exp_q.pop_front();
        @(negedge clk);
        chk_now(s.nm, s.d);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] extras [6];
    logic [1:0]  c;

    extras[0] = 64'h0080_0000_8000_0000;
    extras[1] = 64'h03F0_0000_03F0_0000;
    extras[2] = 64'h0BF0_0000_83F0_0000;
    extras[3] = ~64'h0BF0_0000_83F0_0000;
    extras[4] = 64'h0080_0000_83F0_0000;
    extras[5] = 64'hFF7F_FFFF_7FFF_FFFF;

    // Reset held from time zero with a live decode on the inputs
    rst_n = 1'b0;
    word  = 64'h12345678_9ABCDEF0;
    pe    = 1'b0;
    tkk   = 1'b0;
    #2;
    chk_now("rst_init", '0);
    @(posedge clk);
    @(negedge clk);
    chk_now("rst_hold_init", '0);
    #1;
    rst_n = 1'b1;
    begin
      sb_t s;
      s.d = mk(4'h1, 8'h23, 1'b0, 20'h45678); s.nm = "nat_left";
      exp_q.push_back(s);
    end

    step(64'h12345678_9ABCDEF0, 1'b0, 1'b1, mk(4'h9, 8'hAB, 1'b1, 20'hCDEF0), "nat_right");
`ifdef BESM6_COMPAT_EN
    step(64'hFFFF0000_003A9234, 1'b1, 1'b1, mk(4'h3, 8'h15, 1'b1, 20'h01234), "b6_long_right");
    step(64'h000076A3_45000000, 1'b1, 1'b0, mk(4'h7, 8'h2A, 1'b0, 20'h07345), "b6_short_left");
`else
    step(64'hFFFF0000_003A9234, 1'b1, 1'b1, mk(4'h0, 8'h03, 1'b0, 20'hA9234), "b6_long_right");
    step(64'h000076A3_45000000, 1'b1, 1'b0, mk(4'h0, 8'h00, 1'b0, 20'h076A3), "b6_short_left");
`endif
    step(64'h12345678_9ABCDEF0, 1'b0, 1'b1, mk(4'h9, 8'hAB, 1'b1, 20'hCDEF0), "pre_rst");

    // Asynchronous reset between edges, with a different pending input
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_now("rst_async", '0);
    word = 64'h12345678_9ABCDEF0; pe = 1'b0; tkk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_now("rst_hold", '0);
    #1;
    rst_n = 1'b1;
    begin
      sb_t s;
      s.d = mk(4'h1, 8'h23, 1'b0, 20'h45678); s.nm = "rst_release";
      exp_q.push_back(s);
    end

    // Walking-1, walking-0 and forced-field variants under every pe/tkk pair
    for (int b = 0; b < 64; b++) begin
      w = 64'h1 << b;
      for (int k = 0; k < 4; k++) begin
        c = 2'(k);
        step(w, c[1], c[0], ref_model(w, c[1], c[0]), "walk1");
      end
    end
    for (int b = 0; b < 64; b++) begin
      w = ~(64'h1 << b);
      for (int k = 0; k < 4; k++) begin
        c = 2'(k);
        step(w, c[1], c[0], ref_model(w, c[1], c[0]), "walk0");
      end
    end
    for (int x = 0; x < 6; x++) begin
      for (int k = 0; k < 4; k++) begin
        c = 2'(k);
        step(extras[x], c[1], c[0], ref_model(extras[x], c[1], c[0]), "variant");
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insn_decoder.md
# insn_decoder

Instruction-field decoder for the micro-BESM processor. It takes a 64-bit instruction word holding two packed instructions. It selects the left or right instruction and splits it into modifier index, opcode, extended-opcode flag and address. Both the native micro-BESM format and the BESM-6 compatibility format are supported. It sits between instruction fetch and the microprogram sequencer; its registered outputs feed opcode dispatch and address formation.

## Interface
- No parameters.
- clk  in  1  system clock; all outputs update on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- word  in  64  fetched instruction word.
- pe  in  1  1 = BESM-6 compatibility format, 0 = native format.
- tkk  in  1  half select: 0 = left instruction, 1 = right instruction.
- ir  out  4  modifier (index register) number.
- op  out  8  opcode.
- extop  out  1  extended/long-format opcode flag.
- addr  out  20  address field, zero-extended.

## Operation
- **Native format (pe=0).**
  - Half h[31:0] = tkk ? word[31:0] : word[63:32].
  - ir = h[31:28], op = h[27:20], extop = h[27], addr = h[19:0].
- **BESM-6 format (pe=1).**
  - Only word[47:0] is used; word[63:48] (tag bits) is ignored.
  - Half h[23:0] = tkk ? word[23:0] : word[47:24].
  - ir = h[23:20] in both sub-formats.
- **Long format (h[19]=1):**
  - extop = 1
  - op = {3'b000, 1'b1, h[18:15]}, i.e. opcodes 0x10–0x1F
  - addr = {5'b0, h[14:0]}
- **Short format (h[19]=0):**
  - extop = 0
  - op = {2'b00, h[17:12]}
  - addr = {5'b0, h[18] ? 3'b111 : 3'b000, h[11:0]}; h[18] selects the 070000-octal address region.
- **Unused bits.** Inputs not named above have no effect on any output. All four combinations of pe and tkk are legal on every cycle.

## Timing
- The decode is combinational. All four outputs are registered together: latency is exactly 1 clk from inputs to outputs.
- A new input is accepted every cycle; there is no handshake and no stall.
- rst_n low forces ir, op, extop and addr to 0 immediately, without waiting for a clock edge, and holds them at 0 while low.
- The first rising edge after rst_n deasserts captures the decode of the current inputs.
- Reset asserted mid-stream discards the pending decode; no partial update occurs.
- Changing pe or tkk between cycles has no history effect; each cycle decodes independently.

## Configuration
- **BESM6_COMPAT_EN defined:** behaviour exactly as above.
- **BESM6_COMPAT_EN undefined:**
  - The pe input remains a port but is ignored.
  - Every word decodes in native format.
  - The BESM-6 field logic is not compiled.

## Structure
- **Package insn_pkg** holds:
  - field-position localparams (native IR/OP/ADDR msb/lsb; BESM-6 IR, LONG bit, short/long op and address ranges)
  - the constant 3'b111 used for address extension
  - a packed struct typedef decoded_insn_t {ir, op, extop, addr}
- **Sub-module besm6_unpack** (combinational): takes a 24-bit half and returns decoded_insn_t. It is instantiated once, behind the BESM6_COMPAT_EN guard.
- The native decode and the output registers live in the top module.

## Test plan
- **Native, left half.** pe=0, tkk=0, word=64'h12345678_9ABCDEF0 -> after 1 clk: ir=1, op=8'h23, extop=0, addr=20'h45678.
- **Native, right half.** pe=0, tkk=1, same word -> ir=9, op=8'hAB, extop=1, addr=20'hCDEF0.
- **BESM-6 long, right half.** pe=1, tkk=1, word=64'hFFFF0000_003A9234 (tag bits set, must be ignored) -> ir=3, op=8'h15, extop=1, addr=20'h01234.
- **BESM-6 short with extension, left half.** pe=1, tkk=0, word=64'h000076A3_45000000 -> ir=7, op=8'h2A, extop=0, addr=20'h07345.
- **Asynchronous reset.** Drive a decoding that gives nonzero outputs, then pull rst_n low between clock edges -> all outputs 0 before the next edge. Release rst_n -> the first edge restores the decode.
- **Sweep.** Walking-1 and walking-0 words across all 64 bits, plus variants with bit 31, bit 55 and op fields 8'h3F (bits 27:20 / 59:52) forced, each run under all four pe/tkk combinations -> outputs match a reference model bit-exactly. Repeat with BESM6_COMPAT_EN undefined: pe=1 results equal the pe=0 results.
